// File: rtl/mem_arbiter_pkg.sv
// Purpose: shared widths, constants, state encoding and bus transaction record for mem_arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

  localparam int REG_BUS_D = 32;
  localparam int SEL_W     = 4;

  typedef logic [REG_BUS_D-1:0] word_t;

  localparam word_t            ZERO_WORD = '0;
  localparam logic [SEL_W-1:0] SEL_ALL   = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    BUS_IF  = 2'b01,
    BUS_LSU = 2'b10
  } arb_state_e;

  // Everything latched from the winning requester at grant time.
  typedef struct packed {
    logic             we;
    word_t            a;
    logic [SEL_W-1:0] sel;
    word_t            wd;
  } bus_txn_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Purpose: busy-cycle watchdog for the memory arbiter.
// Latency: expired is combinational in the busy cycle whose count would reach TIMEOUT_CYC.
// Backpressure: none; counts only while enable is high, clear has priority.
//
// Ports: clk_i, rs_n_i (async active-low), clear (new grant), enable (busy cycle
// without bus ack), expired (this cycle is the TIMEOUT_CYC-th unacknowledged one).
module mem_arb_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk_i,
  input  logic rs_n_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fire in the cycle whose increment would make the count reach TIMEOUT_CYC,
  // so the owner is released after exactly TIMEOUT_CYC busy cycles.
  assign expired = enable && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates instruction-fetch and LSU accesses onto one shared RAM port.
// Latency: bus_req_o one cycle after the request is sampled; ack/err one cycle after bus_ack_i/timeout.
// Backpressure: requesters hold their request until ack/err; stall_req_o tells control someone waits.
//
// Ports: clk_i, rs_n_i (async active-low); if_req_i/if_a_i -> if_ack_o/if_err_o/if_rd_o;
// lsu_ce_i/lsu_we_i/lsu_a_i/lsu_sel_i/lsu_wd_i -> lsu_ack_o/lsu_err_o/lsu_rd_o;
// bus_req_o/bus_we_o/bus_a_o/bus_sel_o/bus_wd_o <- bus_ack_i/bus_rd_i; stall_req_o.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC   = 255,
  parameter int LSU_BURST_MAX = 4
) (
  input  logic                 clk_i,
  input  logic                 rs_n_i,
  input  logic                 if_req_i,
  input  logic [REG_BUS_D-1:0] if_a_i,
  output logic                 if_ack_o,
  output logic                 if_err_o,
  output logic [REG_BUS_D-1:0] if_rd_o,
  input  logic                 lsu_ce_i,
  input  logic                 lsu_we_i,
  input  logic [REG_BUS_D-1:0] lsu_a_i,
  input  logic [SEL_W-1:0]     lsu_sel_i,
  input  logic [REG_BUS_D-1:0] lsu_wd_i,
  output logic                 lsu_ack_o,
  output logic                 lsu_err_o,
  output logic [REG_BUS_D-1:0] lsu_rd_o,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [REG_BUS_D-1:0] bus_a_o,
  output logic [SEL_W-1:0]     bus_sel_o,
  output logic [REG_BUS_D-1:0] bus_wd_o,
  input  logic                 bus_ack_i,
  input  logic [REG_BUS_D-1:0] bus_rd_i,
  output logic                 stall_req_o
);

  localparam int BW = $clog2(LSU_BURST_MAX + 1);

  arb_state_e    state_q, state_d;
  bus_txn_t      txn_q, txn_d;
  logic          bus_req_q, bus_req_d;
  word_t         if_rd_q, if_rd_d, lsu_rd_q, lsu_rd_d;
  logic          if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic          lsu_ack_q, lsu_ack_d, lsu_err_q, lsu_err_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          grant_if, grant_lsu, busy, tmo;

  // LSU wins unless IF has already been passed over LSU_BURST_MAX times in a row.
  always_comb begin
    grant_if  = 1'b0;
    grant_lsu = 1'b0;
    if (state_q == IDLE) begin
      if (lsu_ce_i && !(if_req_i && (burst_q == BW'(LSU_BURST_MAX)))) begin
        grant_lsu = 1'b1;
      end else if (if_req_i) begin
        grant_if = 1'b1;
      end
    end
  end

  assign busy = (state_q != IDLE);

  mem_arb_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk_i   (clk_i),
    .rs_n_i  (rs_n_i),
    .clear   (grant_if | grant_lsu),
    .enable  (busy & ~bus_ack_i),
    .expired (tmo)
  );

  always_comb begin
    state_d   = state_q;
    txn_d     = txn_q;
    bus_req_d = bus_req_q;
    if_rd_d   = if_rd_q;
    lsu_rd_d  = lsu_rd_q;
    if_ack_d  = 1'b0;
    if_err_d  = 1'b0;
    lsu_ack_d = 1'b0;
    lsu_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // bus_ack_i is deliberately not looked at here.
        if (grant_lsu) begin
          state_d   = BUS_LSU;
          txn_d     = '{we: lsu_we_i, a: lsu_a_i, sel: lsu_sel_i, wd: lsu_wd_i};
          bus_req_d = 1'b1;
        end else if (grant_if) begin
          state_d   = BUS_IF;
          txn_d     = '{we: 1'b0, a: if_a_i, sel: SEL_ALL, wd: ZERO_WORD};
          bus_req_d = 1'b1;
        end
      end
      BUS_IF, BUS_LSU: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (bus_ack_i) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (state_q == BUS_IF) begin
            if_rd_d  = bus_rd_i;
            if_ack_d = 1'b1;
          end else begin
            lsu_rd_d  = bus_rd_i;
            lsu_ack_d = 1'b1;
          end
        end else if (tmo) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (state_q == BUS_IF) begin
            if_rd_d  = ZERO_WORD;
            if_err_d = 1'b1;
          end else begin
            lsu_rd_d  = ZERO_WORD;
            lsu_err_d = 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // A cycle with no IF request breaks the streak; so does serving IF.
  always_comb begin
    burst_d = burst_q;
    if (!if_req_i || grant_if) begin
      burst_d = '0;
    end else if (grant_lsu) begin
      burst_d = burst_q + BW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rs_n_i) begin
    if (!rs_n_i) begin
      state_q   <= IDLE;
      txn_q     <= '0;
      bus_req_q <= 1'b0;
      if_rd_q   <= ZERO_WORD;
      lsu_rd_q  <= ZERO_WORD;
      if_ack_q  <= 1'b0;
      if_err_q  <= 1'b0;
      lsu_ack_q <= 1'b0;
      lsu_err_q <= 1'b0;
      burst_q   <= '0;
    end else begin
      state_q   <= state_d;
      txn_q     <= txn_d;
      bus_req_q <= bus_req_d;
      if_rd_q   <= if_rd_d;
      lsu_rd_q  <= lsu_rd_d;
      if_ack_q  <= if_ack_d;
      if_err_q  <= if_err_d;
      lsu_ack_q <= lsu_ack_d;
      lsu_err_q <= lsu_err_d;
      burst_q   <= burst_d;
    end
  end

  assign bus_req_o = bus_req_q;
  assign bus_we_o  = txn_q.we;
  assign bus_a_o   = txn_q.a;
  assign bus_sel_o = txn_q.sel;
  assign bus_wd_o  = txn_q.wd;
  assign if_ack_o  = if_ack_q;
  assign if_err_o  = if_err_q;
  assign if_rd_o   = if_rd_q;
  assign lsu_ack_o = lsu_ack_q;
  assign lsu_err_o = lsu_err_q;
  assign lsu_rd_o  = lsu_rd_q;

  // A requester being acked this cycle is not waiting; gated so reset forces it low.
  assign stall_req_o = rs_n_i & ((if_req_i & ~if_ack_q) | (lsu_ce_i & ~lsu_ack_q));

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter (directed cases, then randomized transactions).
// Latency: expects bus_req_o one cycle after a request and ack/err one cycle after bus ack/timeout.
// Backpressure: the bench acts as both requesters and as a RAM with programmable ack latency.
module tb_mem_arbiter;

  localparam int TMO   = 8;
  localparam int BURST = 4;

  logic        clk_i = 1'b0;
  logic        rs_n_i;
  logic        if_req_i, lsu_ce_i, lsu_we_i, bus_ack_i;
  logic [31:0] if_a_i, lsu_a_i, lsu_wd_i, bus_rd_i;
  logic [3:0]  lsu_sel_i;
  logic        if_ack_o, if_err_o, lsu_ack_o, lsu_err_o;
  logic        bus_req_o, bus_we_o, stall_req_o;
  logic [31:0] if_rd_o, lsu_rd_o, bus_a_o, bus_wd_o;
  logic [3:0]  bus_sel_o;

  int errors = 0;
  int checks = 0;

  // Reference model state: IF pass-over streak and last completed data per requester.
  int          streak;
  logic [31:0] exp_if_rd, exp_lsu_rd;
  int          who;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.TIMEOUT_CYC(TMO), .LSU_BURST_MAX(BURST)) dut (
    .clk_i       (clk_i),
    .rs_n_i      (rs_n_i),
    .if_req_i    (if_req_i),
    .if_a_i      (if_a_i),
    .if_ack_o    (if_ack_o),
    .if_err_o    (if_err_o),
    .if_rd_o     (if_rd_o),
    .lsu_ce_i    (lsu_ce_i),
    .lsu_we_i    (lsu_we_i),
    .lsu_a_i     (lsu_a_i),
    .lsu_sel_i   (lsu_sel_i),
    .lsu_wd_i    (lsu_wd_i),
    .lsu_ack_o   (lsu_ack_o),
    .lsu_err_o   (lsu_err_o),
    .lsu_rd_o    (lsu_rd_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_a_o     (bus_a_o),
    .bus_sel_o   (bus_sel_o),
    .bus_wd_o    (bus_wd_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rd_i    (bus_rd_i),
    .stall_req_o (stall_req_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called mid-cycle while the arbiter is idle (or issuing a pulse). Drives one request
  // pattern, lets the RAM respond in busy cycle 'lat' (never if lat > TMO) and checks
  // the whole transaction. who: 0 = nothing granted, 1 = IF, 2 = LSU (observed).
  task automatic run_txn(input bit ir, input bit lc, input logic [31:0] ia, input bit we,
                         input logic [31:0] la, input logic [3:0] sel, input logic [31:0] wd,
                         input int lat, input logic [31:0] rdat, input bit drop,
                         output int obs_who);
    bit          win_if, win_lsu, tmo;
    int          nb;
    logic [31:0] ea;
    logic        ewe;
    logic [3:0]  esel;
    if_req_i  = ir;  if_a_i  = ia;
    lsu_ce_i  = lc;  lsu_we_i = we; lsu_a_i = la; lsu_sel_i = sel; lsu_wd_i = wd;
    win_lsu   = lc && !(ir && streak == BURST);
    win_if    = ir && !win_lsu;
    if (!ir || win_if) streak = 0;
    else if (win_lsu)  streak = streak + 1;
    step();
    chk32("pulse_clear", 32'({if_ack_o, if_err_o, lsu_ack_o, lsu_err_o}), 32'd0);
    obs_who = 0;
    if (!win_if && !win_lsu) begin
      chk1("idle_no_req", bus_req_o, 1'b0);
      return;
    end
    ea   = win_if ? ia : la;
    ewe  = win_if ? 1'b0 : we;
    esel = win_if ? 4'hF : sel;
    if (drop) begin
      if (win_if) if_req_i = 1'b0;
      else        lsu_ce_i = 1'b0;
    end
    tmo = (lat > TMO);
    nb  = tmo ? TMO : lat;
    for (int k = 1; k <= nb; k++) begin
      chk1 ("bus_req", bus_req_o, 1'b1);
      chk32("bus_a", bus_a_o, ea);
      chk1 ("bus_we", bus_we_o, ewe);
      chk32("bus_sel", 32'(bus_sel_o), 32'(esel));
      if (win_lsu) chk32("bus_wd", bus_wd_o, wd);
      chk32("busy_no_pulse", 32'({if_ack_o, if_err_o, lsu_ack_o, lsu_err_o}), 32'd0);
      if (k == lat) begin bus_ack_i = 1'b1; bus_rd_i = rdat; end
      else          begin bus_ack_i = 1'b0; bus_rd_i = $urandom; end
      step();
    end
    bus_ack_i = 1'b0;
    if (win_if) exp_if_rd  = tmo ? 32'd0 : rdat;
    else        exp_lsu_rd = tmo ? 32'd0 : rdat;
    chk1 ("bus_req_drop", bus_req_o, 1'b0);
    chk1 ("if_ack", if_ack_o, win_if && !tmo);
    chk1 ("if_err", if_err_o, win_if && tmo);
    chk1 ("lsu_ack", lsu_ack_o, win_lsu && !tmo);
    chk1 ("lsu_err", lsu_err_o, win_lsu && tmo);
    chk32("if_rd", if_rd_o, exp_if_rd);
    chk32("lsu_rd", lsu_rd_o, exp_lsu_rd);
    chk1 ("stall", stall_req_o, (if_req_i && !(win_if && !tmo)) || (lsu_ce_i && !(win_lsu && !tmo)));
    if (if_ack_o || if_err_o) obs_who = 1;
    else if (lsu_ack_o || lsu_err_o) obs_who = 2;
  endtask

  initial begin
    rs_n_i = 1'b0;
    if_req_i = 1'b1; lsu_ce_i = 1'b1; lsu_we_i = 1'b0; bus_ack_i = 1'b1;
    if_a_i = 32'h44; lsu_a_i = 32'h88; lsu_sel_i = 4'hF; lsu_wd_i = 32'h1; bus_rd_i = 32'hFFFF_FFFF;
    streak = 0; exp_if_rd = 32'd0; exp_lsu_rd = 32'd0; who = 0;

    // Reset state, with inputs active to show they cannot leak through.
    #12;
    chk1 ("rst_bus_req", bus_req_o, 1'b0);
    chk32("rst_bus_a", bus_a_o, 32'd0);
    chk32("rst_pulses", 32'({if_ack_o, if_err_o, lsu_ack_o, lsu_err_o}), 32'd0);
    chk32("rst_if_rd", if_rd_o, 32'd0);
    chk32("rst_lsu_rd", lsu_rd_o, 32'd0);
    chk1 ("rst_stall", stall_req_o, 1'b0);
    if_req_i = 1'b0; lsu_ce_i = 1'b0;
    #5 rs_n_i = 1'b1;

    // Bus ack while idle must be ignored.
    step(); step();
    chk32("idle_ack_ignored", 32'({if_ack_o, lsu_ack_o, bus_req_o}), 32'd0);
    chk32("idle_ack_rd", lsu_rd_o, 32'd0);
    bus_ack_i = 1'b0;

    // LSU load, store, IF read, IF timeout, ack/timeout coincidence, mid-transaction drop.
    run_txn(0, 1, 32'h0, 0, 32'h100, 4'hF, 32'h0, 3, 32'hDEADBEEF, 0, who);
    chk32("load_owner", 32'(who), 32'd2);
    run_txn(0, 1, 32'h0, 1, 32'h200, 4'b0011, 32'h1234ABCD, 4, 32'h5555AAAA, 0, who);
    chk32("store_owner", 32'(who), 32'd2);
    run_txn(1, 0, 32'h400, 0, 32'h0, 4'h0, 32'h0, 1, 32'hCAFEF00D, 0, who);
    chk32("if_owner", 32'(who), 32'd1);
    run_txn(1, 0, 32'h404, 0, 32'h0, 4'h0, 32'h0, 100, 32'h0, 0, who);
    chk32("timeout_owner", 32'(who), 32'd1);
    run_txn(0, 1, 32'h0, 0, 32'h300, 4'b1100, 32'h0, TMO, 32'h0BADC0DE, 0, who);
    chk32("coincide_owner", 32'(who), 32'd2);
    run_txn(0, 1, 32'h0, 0, 32'h304, 4'hF, 32'h0, 2, 32'h76543210, 1, who);
    chk32("drop_owner", 32'(who), 32'd2);

    // Both held: four LSU grants, then IF, then LSU again.
    for (int i = 0; i < 6; i++) begin
      run_txn(1, 1, 32'h800 + 32'(i), 0, 32'h900 + 32'(i), 4'hF, 32'h0,
              $urandom_range(1, 3), $urandom, 0, who);
      chk32("burst_seq", 32'(who), (i == 4) ? 32'd1 : 32'd2);
    end

    // Reset in the middle of an LSU transaction.
    if_req_i = 1'b0; lsu_ce_i = 1'b1; lsu_we_i = 1'b0; lsu_a_i = 32'hA00;
    step();
    chk1("rst_mid_busy", bus_req_o, 1'b1);
    step();
    #3 rs_n_i = 1'b0;
    #1 chk1("rst_mid_req_drop", bus_req_o, 1'b0);
    lsu_ce_i = 1'b0;
    #3 rs_n_i = 1'b1;
    bus_ack_i = 1'b1; bus_rd_i = 32'h13572468;
    for (int i = 0; i < 3; i++) begin
      step();
      chk32("rst_mid_no_pulse", 32'({lsu_ack_o, lsu_err_o, if_ack_o, if_err_o, bus_req_o}), 32'd0);
    end
    bus_ack_i = 1'b0;
    streak = 0; exp_if_rd = 32'd0; exp_lsu_rd = 32'd0;
    chk32("rst_mid_rd", lsu_rd_o, 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 60; n++) begin
      run_txn(1'($urandom % 4 != 0), 1'($urandom % 4 != 0), $urandom, 1'($urandom),
              $urandom, 4'($urandom), $urandom, $urandom_range(1, 10), $urandom,
              1'($urandom % 4 == 0), who);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
